// File: rtl/mips_multicycle_control_pkg.sv
// Shared types for the multi-cycle MIPS control path: opcode/funct codes,
// ALU control encoding, datapath mux selects and the control FSM states.
// Optional feature macro: MIPS_ILLEGAL_OP_TRAP_EN (adds the TRAP state).
package MIPS_pkg;

  localparam int MIPS_OP_WIDTH    = 6;
  localparam int MIPS_FUNCT_WIDTH = 6;

  typedef enum logic [5:0] {
    OP_R    = 6'b000000,
    OP_J    = 6'b000010,
    OP_BEQ  = 6'b000100,
    OP_ADDI = 6'b001000,
    OP_LW   = 6'b100011,
    OP_SW   = 6'b101011
  } mips_op_e;

  typedef enum logic [5:0] {
    FUNCT_ADD = 6'b100000,
    FUNCT_SUB = 6'b100010,
    FUNCT_AND = 6'b100100,
    FUNCT_OR  = 6'b100101,
    FUNCT_SLT = 6'b101010
  } mips_funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } mips_alu_ctrl_e;

  // Coarse ALU request from the FSM; the decoder refines FUNCT via funct.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } mips_aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } mips_srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } mips_pcsrc_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
    S_JUMP,
    S_TRAP
`else
    S_JUMP
`endif
  } mips_ctrl_state_e;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle. master = control FSM, slave = datapath.
interface mips_multicycle_control_if #(
  parameter int OP_W    = MIPS_pkg::MIPS_OP_WIDTH,
  parameter int FUNCT_W = MIPS_pkg::MIPS_FUNCT_WIDTH
);
  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_write;
  logic               iord;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_ctrl;
  logic [1:0]         pc_src;
  logic               pc_en;
  logic               illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal
  );
endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's coarse aluop plus the R-type funct field to
// the 3-bit ALU operation. Unknown funct values fall back to ADD.
module mips_alu_decoder
  import MIPS_pkg::*;
#(
  parameter int FUNCT_W = MIPS_FUNCT_WIDTH
) (
  input  logic [FUNCT_W-1:0] funct,
  input  mips_aluop_e        aluop,
  output logic [2:0]         alu_ctrl
);

  // Pure combinational lookup.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core. Moore decode of the
// registered state, except FETCH ir_write/pc_en (= mem_ready) and BRANCH
// pc_en (= zero). Reset forces all enables low, aborting any memory access.
// Optional feature macro: MIPS_ILLEGAL_OP_TRAP_EN (unsupported opcode ->
// TRAP with sticky illegal flag; otherwise such opcodes act as a NOP).
module mips_multicycle_control
  import MIPS_pkg::*;
#(
  parameter int OP_W    = MIPS_OP_WIDTH,
  parameter int FUNCT_W = MIPS_FUNCT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_multicycle_control_if.master bus
);

  mips_ctrl_state_e   state_reg, state_next;
  logic [OP_W-1:0]    op_s;
  logic [FUNCT_W-1:0] funct_s;
  mips_aluop_e        aluop;
  logic [2:0]         alu_ctrl_dec;
  logic               alu_used;
  logic               mem_req_c, mem_write_c, iord_c, ir_write_c;
  logic               reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, pc_en_c;
  mips_srcb_e         alu_src_b_c;
  mips_pcsrc_e        pc_src_c;

  assign op_s    = bus.op;
  assign funct_s = bus.funct;

  mips_alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_dec (
    .funct    (funct_s),
    .aluop    (aluop),
    .alu_ctrl (alu_ctrl_dec)
  );

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_next   = state_reg;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_B;
    pc_src_c     = PCSRC_ALU;
    pc_en_c      = 1'b0;
    aluop        = ALUOP_ADD;
    alu_used     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        alu_used    = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH;
        alu_used    = 1'b1;
        case (op_s)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_used    = 1'b1;
        state_next  = (op_s == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        aluop       = ALUOP_FUNCT;
        alu_used    = 1'b1;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        aluop       = ALUOP_SUB;
        alu_used    = 1'b1;
        pc_src_c    = PCSRC_ALUOUT;
        pc_en_c     = bus.zero;
        state_next  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_used    = 1'b1;
        state_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c   = PCSRC_JUMP;
        pc_en_c    = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Enables are killed during reset so an in-flight access is aborted.
  assign bus.mem_req    = mem_req_c   & ~rst;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.ir_write   = ir_write_c  & ~rst;
  assign bus.reg_write  = reg_write_c & ~rst;
  assign bus.pc_en      = pc_en_c     & ~rst;
  assign bus.iord       = iord_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_ctrl   = alu_used ? alu_ctrl_dec : 3'b000;

`ifdef MIPS_ILLEGAL_OP_TRAP_EN
  // TRAP is absorbing until reset, which makes the flag sticky.
  assign bus.illegal = (state_reg == S_TRAP) & ~rst;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the non-pipelined multi-cycle MIPS core. It decodes the latched instruction's `op`/`funct` fields and sequences the shared datapath (PC, instruction register, unified memory port, register file, single ALU) one micro-step per cycle. It also stalls on memory via a ready handshake. It sits beside the datapath top and drives every mux select and write enable in it.

## Interface
Parameters:
- `OP_W`, 6, opcode field width (`MIPS_OP_WIDTH`)
- `FUNCT_W`, 6, funct field width (`MIPS_FUNCT_WIDTH`)

Ports:
- `clk`  in  1  single core clock; everything is on the rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `op`  in  OP_W  opcode from the instruction register
- `funct`  in  FUNCT_W  funct from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current access
- `mem_req`  out  1  memory access is active
- `mem_write`  out  1  access is a store
- `iord`  out  1  address mux: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load the instruction register
- `reg_dst`  out  1  write-register mux: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-data mux: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A mux: 0 = PC, 1 = A register
- `alu_src_b`  out  2  ALU B mux: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- `alu_ctrl`  out  3  ALU operation
- `pc_src`  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pc_en`  out  1  PC write enable
- `illegal`  out  1  sticky illegal-opcode flag (only with the macro)

## Operation
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Supported funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- `alu_ctrl` encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- States and transitions:
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_src`=00. Holds while `!mem_ready`. On `mem_ready`: `ir_write`=1 and `pc_en`=1 for that cycle, then go to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, ADD (computes the branch target). Next state: LW/SW → MEMADR, R → EXEC, BEQ → BRANCH, ADDI → ADDIEX, J → JUMP, other → illegal handling (see Configuration).
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. LW → MEMRD, SW → MEMWR.
  - MEMRD: `mem_req`=1, `iord`=1. Holds until `mem_ready`, then → MEMWB.
  - MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. → FETCH.
  - MEMWR: `mem_req`=1, `mem_write`=1, `iord`=1. Holds until `mem_ready`, then → FETCH.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct. → ALUWB.
  - ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01, `pc_en`=`zero`. → FETCH.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=10, ADD. → ADDIWB.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. → FETCH.
  - JUMP: `pc_src`=10, `pc_en`=1. → FETCH.
- An R-type instruction with an unsupported funct executes as ADD (`alu_ctrl`=010).
- Every output not listed for a state is 0.

## Timing
- Outputs are a Moore decode of the registered state. The exceptions are `pc_en` in FETCH (= `mem_ready`) and in BRANCH (= `zero`), and `ir_write` in FETCH (= `mem_ready`); these are combinational from the inputs.
- Latency with zero wait states: BEQ/J 3 cycles, R/SW/ADDI 4, LW 5. Each wait cycle adds 1.
- `mem_ready` is sampled only while `mem_req`=1 and is ignored otherwise. A ready with no request causes no state change.
- Reset: while `rst`=1, `mem_req`, `mem_write`, `ir_write`, `reg_write` and `pc_en` are forced to 0 and `illegal` clears. The state is FETCH from the first edge after `rst` falls.
- Reset asserted mid-access (MEMWR, MEMRD) aborts the access. No write enable is asserted in that cycle.
- `op`/`funct` are sampled in DECODE and in later states. The instruction register is stable there because `ir_write`=0.

## Configuration
- `MIPS_ILLEGAL_OP_TRAP_EN` defined:
  - An unsupported opcode in DECODE moves to state TRAP.
  - In TRAP, all enables are 0 and `illegal`=1.
  - TRAP is left only by `rst`.
- Not defined:
  - An unsupported opcode returns DECODE → FETCH, so the instruction executes as a NOP (2 cycles).
  - The `illegal` port is tied to 0, and the TRAP state does not exist.

## Structure
- The state enum `mips_ctrl_state_e`, `mips_alu_ctrl_e` and the mux-select encodings belong in `MIPS_pkg`.
- Extend `mips_op_e` and `mips_funct_e` in `MIPS_pkg` with the codes listed above.
- One sub-module, `mips_alu_decoder`: combinational mapping of `funct` plus a 2-bit aluop (ADD/SUB/funct) to `alu_ctrl`.

## Test plan
- Reset, then LW (op 100011) with `mem_ready`=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 and `mem_to_reg`=1 in cycle 5.
- SW with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held for 4 cycles, then FETCH, with no `reg_write` at any point.
- BEQ with `zero`=1 → `pc_en`=1 and `pc_src`=01 in cycle 3. Repeat with `zero`=0 → `pc_en`=0.
- R-type with funct 101010 → `alu_ctrl`=111 in EXEC. ALUWB asserts `reg_dst`=1 and `reg_write`=1.
- Op 111111 → with the macro, `illegal`=1 from cycle 3 until `rst`. Without the macro, the state is back in FETCH on cycle 3.
- `rst` pulsed during MEMWR with `mem_ready`=1 → `mem_write`=0 in that cycle, and the state is FETCH after `rst` falls.
